mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: Im  in  32  current IR contents {op,rs,rt,imm16} from datapath.
REQ-004 SHALL expose: Zero  in  3  ALU flags; [0]=A==B, [1]=A<B signed, [2]=slt result.
REQ-005 SHALL expose outputs PCWr, IRWr, RegWr, MemWr, ExtOp, ALUSelA, ALUSelB (1 bit each).
REQ-006 SHALL expose outputs NPCOp, WDSel, RegDst (2 bits each); ALUOp (4); whb (8); state (4, debug).
REQ-007 NPCOp SHALL encode 00 PC+4, 01 branch target, 10 jump target, 11 register (jr).
REQ-008 WDSel SHALL encode 00 ALUOUT, 01 memory data, 10 PC+4 (link), 11 Zero[2].
REQ-009 RegDst SHALL encode 00 rt, 01 rd, 10 $31.
REQ-010 whb SHALL be 8'h01 word, 8'h04 signed byte, 8'h00 when no memory access.

Function
REQ-011 Supported set SHALL be: addu, subu, and, or, slt, jr, addiu, ori, lui, lw, sw, lb, sb, beq, bne, j, jal.
REQ-012 FSM SHALL use states FETCH, DCD, MA, MR, MWB, MW, EXE, AWB, BR, JMP, JAL, JR.
REQ-013 FETCH SHALL assert PCWr=1, IRWr=1, NPCOp=00, then go to DCD.
REQ-014 DCD SHALL assert no write strobes; next state by opcode: lw/lb/sw/sb->MA, R-type/addiu/ori/lui->EXE, beq/bne->BR, j->JMP, jal->JAL, R-type funct jr->JR.
REQ-015 Unsupported opcode/funct SHALL cause DCD->FETCH with no architectural write (executes as NOP).
REQ-016 MA SHALL drive ALUSelB=1, ExtOp=1, ALUOp=ADD; next MR for loads, MW for stores.
REQ-017 MR SHALL hold MA's ALU controls and drive whb (lw 8'h01, lb 8'h04); next MWB.
REQ-018 MWB SHALL assert RegWr=1, RegDst=00, WDSel=01 with whb held; next FETCH.
REQ-019 MW SHALL assert MemWr=1 for exactly one cycle, whb as REQ-010; next FETCH.
REQ-020 EXE SHALL drive ALUOp from funct (R-type) or opcode (I-type); ALUSelB=1 for I-type; ExtOp=1 only for addiu; next AWB.
REQ-021 AWB SHALL assert RegWr=1; RegDst=01 for R-type, 00 for I-type; WDSel=11 for slt, else 00; ALU controls held from EXE; next FETCH.
REQ-022 BR SHALL drive ALUOp=SUB, NPCOp=01, PCWr = Zero[0] (beq) or ~Zero[0] (bne); next FETCH.
REQ-023 JMP SHALL assert PCWr=1, NPCOp=10; next FETCH.
REQ-024 JAL SHALL assert PCWr=1, NPCOp=10, RegWr=1, RegDst=10, WDSel=10 in one cycle; next FETCH.
REQ-025 JR SHALL assert PCWr=1, NPCOp=11; next FETCH.
REQ-026 All outputs SHALL be combinational decodes of state and Im; strobes SHALL be 0 in every state not listed for them.
REQ-027 Cycle counts SHALL be: lw/lb 5, sw/sb 4, ALU 4, branch 3, j/jal/jr 3.

Reset
REQ-028 reset SHALL force state=FETCH immediately, independent of clk, including mid-instruction.
REQ-029 While reset is high, PCWr, IRWr, RegWr, MemWr SHALL be 0; other outputs SHALL be 0.
REQ-030 First rising edge after reset deassertion SHALL perform a FETCH.

Structure
REQ-031 Opcode/funct constants, ALUOp codes (ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5) and state encodings SHALL live in a shared package.
REQ-032 Instruction decode (Im -> instruction class) SHALL be one sub-module, mc_decode; FSM and output logic remain in mc_ctrl.

Verification
REQ-033 Reset mid-MR of lw -> state=FETCH at once, all strobes 0, FETCH on next edge.
REQ-034 Im=lw (op 6'h23) -> states FETCH,DCD,MA,MR,MWB; RegWr=1 only in MWB with WDSel=01, whb=8'h01.
REQ-035 beq with Zero[0]=1 -> PCWr=1, NPCOp=01 in BR; with Zero[0]=0 -> PCWr=0; bne inverted.
REQ-036 jal -> in JAL: PCWr=1, RegWr=1, RegDst=10, WDSel=10, NPCOp=10; back to FETCH in 3 cycles total.
REQ-037 slt (funct 6'h2A) -> AWB with RegDst=01, WDSel=11; MemWr never asserted.
REQ-038 Opcode 6'h3F -> DCD->FETCH, no RegWr/MemWr/PCWr beyond FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes/functs,
// ALU operation codes and the decoded instruction descriptor.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH = 4'd0,
        DCD   = 4'd1,
        MA    = 4'd2,
        MR    = 4'd3,
        MWB   = 4'd4,
        MW    = 4'd5,
        EXE   = 4'd6,
        AWB   = 4'd7,
        BR    = 4'd8,
        JMP   = 4'd9,
        JAL   = 4'd10,
        JR    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;

    localparam logic [7:0] WHB_NONE = 8'h00;
    localparam logic [7:0] WHB_WORD = 8'h01;
    localparam logic [7:0] WHB_BYTE = 8'h04;

    typedef enum logic [3:0] {
        CL_NOP, CL_LOAD, CL_STORE, CL_RALU, CL_IALU,
        CL_BRANCH, CL_J, CL_JAL, CL_JR
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu_op;
        logic       byte_acc;
        logic       is_bne;
        logic       is_slt;
        logic       ext_op;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR contents and ALU flags in, control strobes out.
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [31:0] Im;
    logic [2:0]  Zero;
    logic        PCWr, IRWr, RegWr, MemWr, ExtOp, ALUSelA, ALUSelB;
    logic [1:0]  NPCOp, WDSel, RegDst;
    logic [3:0]  ALUOp;
    logic [7:0]  whb;
    logic [3:0]  state;

    modport master (
        input  Im, Zero,
        output PCWr, IRWr, RegWr, MemWr, ExtOp, ALUSelA, ALUSelB,
        output NPCOp, WDSel, RegDst, ALUOp, whb, state
    );

    modport slave (
        output Im, Zero,
        input  PCWr, IRWr, RegWr, MemWr, ExtOp, ALUSelA, ALUSelB,
        input  NPCOp, WDSel, RegDst, ALUOp, whb, state
    );
endinterface

// File: rtl/mc_decode.sv
// Classifies the IR word into an instruction class plus the few attributes
// the FSM needs; anything unrecognised decodes to CL_NOP.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] im,
    output dec_t        dec
);
    logic [5:0] op, fn;
    logic       unused_im;

    assign op        = im[31:26];
    assign fn        = im[5:0];
    assign unused_im = ^im[25:6];

    always_comb begin
        dec        = '0;
        dec.cls    = CL_NOP;
        dec.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                dec.cls = CL_RALU;
                case (fn)
                    FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  begin dec.alu_op = ALU_SLT; dec.is_slt = 1'b1; end
                    FN_JR:   dec.cls = CL_JR;
                    default: dec.cls = CL_NOP;
                endcase
            end
            OP_ADDIU: begin dec.cls = CL_IALU; dec.alu_op = ALU_ADD; dec.ext_op = 1'b1; end
            OP_ORI:   begin dec.cls = CL_IALU; dec.alu_op = ALU_OR;  end
            OP_LUI:   begin dec.cls = CL_IALU; dec.alu_op = ALU_LUI; end
            OP_LW:    dec.cls = CL_LOAD;
            OP_LB:    begin dec.cls = CL_LOAD;  dec.byte_acc = 1'b1; end
            OP_SW:    dec.cls = CL_STORE;
            OP_SB:    begin dec.cls = CL_STORE; dec.byte_acc = 1'b1; end
            OP_BEQ:   dec.cls = CL_BRANCH;
            OP_BNE:   begin dec.cls = CL_BRANCH; dec.is_bne = 1'b1; end
            OP_J:     dec.cls = CL_J;
            OP_JAL:   dec.cls = CL_JAL;
            default:  dec.cls = CL_NOP;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: state register plus a combinational
// decode of (state, IR) into datapath strobes. Outputs are held at 0 during reset.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    mc_ctrl_if.master bus
);
    state_t     state_q, state_d;
    dec_t       dec;
    logic       pcwr, irwr, regwr, memwr, extop, alusel_b;
    logic [1:0] npcop, wdsel, regdst;
    logic [3:0] aluop;
    logic [7:0] whb;
    logic [7:0] whb_acc;
    logic       unused_zero;

    mc_decode u_decode (.im(bus.Im), .dec(dec));

    assign whb_acc     = dec.byte_acc ? WHB_BYTE : WHB_WORD;
    assign unused_zero = ^bus.Zero[2:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = FETCH;
        pcwr     = 1'b0;
        irwr     = 1'b0;
        regwr    = 1'b0;
        memwr    = 1'b0;
        extop    = 1'b0;
        alusel_b = 1'b0;
        npcop    = 2'b00;
        wdsel    = 2'b00;
        regdst   = 2'b00;
        aluop    = ALU_ADD;
        whb      = WHB_NONE;
        case (state_q)
            FETCH: begin
                pcwr    = 1'b1;
                irwr    = 1'b1;
                state_d = DCD;
            end
            DCD: begin
                case (dec.cls)
                    CL_LOAD, CL_STORE: state_d = MA;
                    CL_RALU, CL_IALU:  state_d = EXE;
                    CL_BRANCH:         state_d = BR;
                    CL_J:              state_d = JMP;
                    CL_JAL:            state_d = JAL;
                    CL_JR:             state_d = JR;
                    default:           state_d = FETCH;
                endcase
            end
            // Address computation stays asserted through the whole memory access.
            MA, MR, MWB, MW: begin
                alusel_b = 1'b1;
                extop    = 1'b1;
                aluop    = ALU_ADD;
                if (state_q != MA) whb = whb_acc;
                case (state_q)
                    MA:      state_d = (dec.cls == CL_STORE) ? MW : MR;
                    MR:      state_d = MWB;
                    MWB:     begin regwr = 1'b1; wdsel = 2'b01; state_d = FETCH; end
                    default: begin memwr = 1'b1; state_d = FETCH; end
                endcase
            end
            EXE, AWB: begin
                aluop    = dec.alu_op;
                alusel_b = (dec.cls == CL_IALU);
                extop    = dec.ext_op;
                if (state_q == EXE) begin
                    state_d = AWB;
                end else begin
                    regwr   = 1'b1;
                    regdst  = (dec.cls == CL_RALU) ? 2'b01 : 2'b00;
                    wdsel   = dec.is_slt ? 2'b11 : 2'b00;
                    state_d = FETCH;
                end
            end
            BR: begin
                aluop = ALU_SUB;
                npcop = 2'b01;
                pcwr  = bus.Zero[0] ^ dec.is_bne;
            end
            JMP: begin
                pcwr  = 1'b1;
                npcop = 2'b10;
            end
            JAL: begin
                pcwr   = 1'b1;
                npcop  = 2'b10;
                regwr  = 1'b1;
                regdst = 2'b10;
                wdsel  = 2'b10;
            end
            JR: begin
                pcwr  = 1'b1;
                npcop = 2'b11;
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.PCWr    = pcwr     & ~reset;
    assign bus.IRWr    = irwr     & ~reset;
    assign bus.RegWr   = regwr    & ~reset;
    assign bus.MemWr   = memwr    & ~reset;
    assign bus.ExtOp   = extop    & ~reset;
    assign bus.ALUSelB = alusel_b & ~reset;
    assign bus.ALUSelA = 1'b0;
    assign bus.NPCOp   = reset ? 2'b00    : npcop;
    assign bus.WDSel   = reset ? 2'b00    : wdsel;
    assign bus.RegDst  = reset ? 2'b00    : regdst;
    assign bus.ALUOp   = reset ? ALU_ADD  : aluop;
    assign bus.whb     = reset ? WHB_NONE : whb;
    assign bus.state   = reset ? FETCH    : state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its
// state sequence and checks the strobes expected in every cycle.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    mc_ctrl_if bus ();
    mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op);
        return {op, 5'd1, 5'd2, 16'h1234};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (bus.state !== 4'(FETCH) || bus.PCWr !== 1'b0 || bus.IRWr !== 1'b0 ||
            bus.RegWr !== 1'b0 || bus.MemWr !== 1'b0 || bus.whb !== 8'h00 || bus.NPCOp !== 2'b00) begin
            fails++;
            $display("FAIL reset_outputs: state=%0d PCWr=%b IRWr=%b RegWr=%b MemWr=%b whb=%h, required all 0",
                     bus.state, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.whb);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (bus.state !== 4'(FETCH) || bus.PCWr !== 1'b1 || bus.IRWr !== 1'b1 || bus.NPCOp !== 2'b00) begin
            fails++;
            $display("FAIL fetch_after_reset: state=%0d PCWr=%b IRWr=%b NPCOp=%b, required FETCH 1 1 00",
                     bus.state, bus.PCWr, bus.IRWr, bus.NPCOp);
        end
    endtask

    task automatic test_load(input logic [5:0] op, input logic [7:0] exp_whb);
        logic [3:0] seq [5];
        seq = '{4'(FETCH), 4'(DCD), 4'(MA), 4'(MR), 4'(MWB)};
        bus.Im = itype(op);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            tests++;
            if (bus.state !== seq[i] || bus.RegWr !== (i == 4) || bus.MemWr !== 1'b0) begin
                fails++;
                $display("FAIL load_seq op=%h cyc=%0d: state=%0d RegWr=%b MemWr=%b, required state=%0d RegWr=%b MemWr=0",
                         op, i, bus.state, bus.RegWr, bus.MemWr, seq[i], (i == 4));
            end
            if (i == 2 || i == 3) begin
                tests++;
                if (bus.ALUSelB !== 1'b1 || bus.ExtOp !== 1'b1 || bus.ALUOp !== 4'd0 ||
                    bus.whb !== ((i == 3) ? exp_whb : 8'h00)) begin
                    fails++;
                    $display("FAIL load_addr op=%h cyc=%0d: ALUSelB=%b ExtOp=%b ALUOp=%0d whb=%h, required 1 1 0 whb=%h",
                             op, i, bus.ALUSelB, bus.ExtOp, bus.ALUOp, bus.whb, (i == 3) ? exp_whb : 8'h00);
                end
            end
        end
        tests++;
        if (bus.WDSel !== 2'b01 || bus.RegDst !== 2'b00 || bus.whb !== exp_whb) begin
            fails++;
            $display("FAIL load_mwb op=%h: WDSel=%b RegDst=%b whb=%h, required 01 00 %h",
                     op, bus.WDSel, bus.RegDst, bus.whb, exp_whb);
        end
        tick();
        tests++;
        if (bus.state !== 4'(FETCH)) begin
            fails++;
            $display("FAIL load_return op=%h: state=%0d, required %0d", op, bus.state, FETCH);
        end
    endtask

    task automatic test_store(input logic [5:0] op, input logic [7:0] exp_whb);
        bus.Im = itype(op);
        tick(); tick();
        tests++;
        if (bus.state !== 4'(MA) || bus.MemWr !== 1'b0) begin
            fails++;
            $display("FAIL store_ma op=%h: state=%0d MemWr=%b, required %0d 0", op, bus.state, bus.MemWr, MA);
        end
        tick();
        tests++;
        if (bus.state !== 4'(MW) || bus.MemWr !== 1'b1 || bus.whb !== exp_whb || bus.RegWr !== 1'b0) begin
            fails++;
            $display("FAIL store_mw op=%h: state=%0d MemWr=%b whb=%h RegWr=%b, required %0d 1 %h 0",
                     op, bus.state, bus.MemWr, bus.whb, bus.RegWr, MW, exp_whb);
        end
        tick();
        tests++;
        if (bus.state !== 4'(FETCH) || bus.MemWr !== 1'b0) begin
            fails++;
            $display("FAIL store_return op=%h: state=%0d MemWr=%b, required FETCH 0", op, bus.state, bus.MemWr);
        end
    endtask

    typedef struct {
        logic [31:0] im;
        logic [3:0]  aluop;
        logic        selb;
        logic        ext;
        logic [1:0]  regdst;
        logic [1:0]  wdsel;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t v [8];
        v[0] = '{rtype(6'h21), 4'd0, 1'b0, 1'b0, 2'b01, 2'b00};
        v[1] = '{rtype(6'h23), 4'd1, 1'b0, 1'b0, 2'b01, 2'b00};
        v[2] = '{rtype(6'h24), 4'd2, 1'b0, 1'b0, 2'b01, 2'b00};
        v[3] = '{rtype(6'h25), 4'd3, 1'b0, 1'b0, 2'b01, 2'b00};
        v[4] = '{rtype(6'h2A), 4'd4, 1'b0, 1'b0, 2'b01, 2'b11};
        v[5] = '{itype(6'h09), 4'd0, 1'b1, 1'b1, 2'b00, 2'b00};
        v[6] = '{itype(6'h0D), 4'd3, 1'b1, 1'b0, 2'b00, 2'b00};
        v[7] = '{itype(6'h0F), 4'd5, 1'b1, 1'b0, 2'b00, 2'b00};
        foreach (v[k]) begin
            bus.Im = v[k].im;
            tick(); tick();
            tests++;
            if (bus.state !== 4'(EXE) || bus.ALUOp !== v[k].aluop || bus.ALUSelB !== v[k].selb ||
                bus.ExtOp !== v[k].ext || bus.RegWr !== 1'b0 || bus.MemWr !== 1'b0) begin
                fails++;
                $display("FAIL alu_exe #%0d: state=%0d ALUOp=%0d ALUSelB=%b ExtOp=%b RegWr=%b, required %0d %0d %b %b 0",
                         k, bus.state, bus.ALUOp, bus.ALUSelB, bus.ExtOp, bus.RegWr, EXE, v[k].aluop, v[k].selb, v[k].ext);
            end
            tick();
            tests++;
            if (bus.state !== 4'(AWB) || bus.RegWr !== 1'b1 || bus.RegDst !== v[k].regdst ||
                bus.WDSel !== v[k].wdsel || bus.ALUOp !== v[k].aluop || bus.MemWr !== 1'b0) begin
                fails++;
                $display("FAIL alu_awb #%0d: state=%0d RegWr=%b RegDst=%b WDSel=%b ALUOp=%0d MemWr=%b, required %0d 1 %b %b %0d 0",
                         k, bus.state, bus.RegWr, bus.RegDst, bus.WDSel, bus.ALUOp, bus.MemWr,
                         AWB, v[k].regdst, v[k].wdsel, v[k].aluop);
            end
            tick();
        end
        tests++;
        if (bus.state !== 4'(FETCH)) begin
            fails++;
            $display("FAIL alu_return: state=%0d, required FETCH", bus.state);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops  [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic       z0   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       expw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.Im   = itype(ops[i]);
            bus.Zero = {2'b00, z0[i]};
            tick(); tick();
            tests++;
            if (bus.state !== 4'(BR) || bus.PCWr !== expw[i] || bus.NPCOp !== 2'b01 ||
                bus.ALUOp !== 4'd1 || bus.RegWr !== 1'b0) begin
                fails++;
                $display("FAIL branch op=%h z=%b: state=%0d PCWr=%b NPCOp=%b ALUOp=%0d, required %0d %b 01 1",
                         ops[i], z0[i], bus.state, bus.PCWr, bus.NPCOp, bus.ALUOp, BR, expw[i]);
            end
            tick();
            tests++;
            if (bus.state !== 4'(FETCH)) begin
                fails++;
                $display("FAIL branch_return op=%h: state=%0d, required FETCH", ops[i], bus.state);
            end
        end
        bus.Zero = 3'b000;
    endtask

    task automatic test_jumps();
        logic [31:0] ims [3];
        logic [3:0]  st  [3] = '{4'(JMP), 4'(JAL), 4'(JR)};
        logic [1:0]  npc [3] = '{2'b10, 2'b10, 2'b11};
        logic        rw  [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  rd  [3] = '{2'b00, 2'b10, 2'b00};
        logic [1:0]  wd  [3] = '{2'b00, 2'b10, 2'b00};
        ims = '{itype(6'h02), itype(6'h03), rtype(6'h08)};
        for (int i = 0; i < 3; i++) begin
            bus.Im = ims[i];
            tick(); tick();
            tests++;
            if (bus.state !== st[i] || bus.PCWr !== 1'b1 || bus.NPCOp !== npc[i] || bus.RegWr !== rw[i] ||
                bus.RegDst !== rd[i] || bus.WDSel !== wd[i] || bus.MemWr !== 1'b0) begin
                fails++;
                $display("FAIL jump #%0d: state=%0d PCWr=%b NPCOp=%b RegWr=%b RegDst=%b WDSel=%b, required %0d 1 %b %b %b %b",
                         i, bus.state, bus.PCWr, bus.NPCOp, bus.RegWr, bus.RegDst, bus.WDSel,
                         st[i], npc[i], rw[i], rd[i], wd[i]);
            end
            tick();
            tests++;
            if (bus.state !== 4'(FETCH)) begin
                fails++;
                $display("FAIL jump_return #%0d: state=%0d, required FETCH", i, bus.state);
            end
        end
    endtask

    task automatic test_nop();
        logic [31:0] ims [2];
        ims = '{itype(6'h3F), rtype(6'h3F)};
        for (int i = 0; i < 2; i++) begin
            bus.Im = ims[i];
            tick();
            tests++;
            if (bus.state !== 4'(DCD) || bus.PCWr !== 1'b0 || bus.IRWr !== 1'b0 ||
                bus.RegWr !== 1'b0 || bus.MemWr !== 1'b0) begin
                fails++;
                $display("FAIL nop_dcd #%0d: state=%0d PCWr=%b IRWr=%b RegWr=%b MemWr=%b, required %0d 0 0 0 0",
                         i, bus.state, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, DCD);
            end
            tick();
            tests++;
            if (bus.state !== 4'(FETCH)) begin
                fails++;
                $display("FAIL nop_return #%0d: state=%0d, required FETCH", i, bus.state);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.Im = itype(6'h23);
        tick(); tick(); tick();
        tests++;
        if (bus.state !== 4'(MR)) begin
            fails++;
            $display("FAIL rmid_pre: state=%0d, required %0d", bus.state, MR);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (bus.state !== 4'(FETCH) || bus.PCWr !== 1'b0 || bus.IRWr !== 1'b0 || bus.RegWr !== 1'b0 ||
            bus.MemWr !== 1'b0 || bus.whb !== 8'h00) begin
            fails++;
            $display("FAIL rmid_async: state=%0d PCWr=%b IRWr=%b RegWr=%b MemWr=%b whb=%h, required FETCH and 0s",
                     bus.state, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.whb);
        end
        @(negedge clk);
        tests++;
        if (bus.state !== 4'(FETCH) || bus.RegWr !== 1'b0) begin
            fails++;
            $display("FAIL rmid_hold: state=%0d RegWr=%b, required FETCH 0", bus.state, bus.RegWr);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (bus.state !== 4'(DCD)) begin
            fails++;
            $display("FAIL rmid_fetch: state=%0d, required %0d", bus.state, DCD);
        end
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        bus.Im   = 32'h0;
        bus.Zero = 3'b000;
        test_reset();
        test_load(6'h23, 8'h01);
        test_load(6'h20, 8'h04);
        test_store(6'h2B, 8'h01);
        test_store(6'h28, 8'h04);
        test_alu();
        test_branch();
        test_jumps();
        test_nop();
        test_reset_mid();
        tests++;
        if (bus.state !== 4'(FETCH)) begin
            fails++;
            $display("FAIL final_state: state=%0d, required FETCH", bus.state);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
